// File: rtl/dmem_bus_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dmem_bus_if : MEM-stage data access unit onto a variable-latency word bus.
// Rev 1.0
// ---------------------------------------------------------------------------
module dmem_bus_if #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic [31:0] rsp_rdata,
    output logic        core_stall,
    output logic        misalign_err,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic [1:0]        off_q, off_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              berr_q, berr_d;

    logic              w_legal;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata;
    logic [31:0]       w_shifted;
    logic [31:0]       w_load;
    logic              w_idle;
    logic              w_busy;

    // Request decode: alignment check, lane enables and lane-replicated data.
    always_comb begin
        w_legal = 1'b0;
        w_be    = 4'b0000;
        w_wdata = 32'h0;
        case (req_size)
            2'b00: begin
                w_legal = (req_addr[1:0] == 2'b00);
                w_be    = 4'b1111;
                w_wdata = req_wdata;
            end
            2'b01: begin
                w_legal = ~req_addr[0];
                w_be    = 4'b0011 << req_addr[1:0];
                w_wdata = {2{req_wdata[15:0]}};
            end
            2'b10: begin
                w_legal = 1'b1;
                w_be    = 4'b0001 << req_addr[1:0];
                w_wdata = {4{req_wdata[7:0]}};
            end
            default: begin
                w_legal = 1'b0;
            end
        endcase
    end

    // Load data is right-aligned and zero-filled above the access size.
    always_comb begin
        w_shifted = mem_rdata >> {off_q, 3'b000};
        case (size_q)
            2'b01:   w_load = {16'h0, w_shifted[15:0]};
            2'b10:   w_load = {24'h0, w_shifted[7:0]};
            default: w_load = w_shifted;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        size_d  = size_q;
        off_d   = off_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rdata_d = rdata_q;
        berr_d  = berr_q;
        case (state_q)
            S_IDLE: begin
                cnt_d  = '0;
                berr_d = 1'b0;
                if (req_valid && w_legal) begin
                    we_d    = req_write;
                    size_d  = req_size;
                    off_d   = req_addr[1:0];
                    addr_d  = {req_addr[31:2], 2'b00};
                    wdata_d = w_wdata;
                    be_d    = w_be;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q + 1'b1;
                if (mem_ready) begin
                    if (!we_q) begin
                        rdata_d = w_load;
                    end
                    state_d = S_DONE;
                end else if (cnt_q == C_CNT_LAST) begin
                    rdata_d = 32'h0;
                    berr_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            off_q   <= 2'b00;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            be_q    <= 4'b0000;
            rdata_q <= 32'h0;
            berr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            size_q  <= size_d;
            off_q   <= off_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            berr_q  <= berr_d;
        end
    end

    // The request-driven outputs are gated by reset so they also read 0 while it is held.
    assign w_idle       = rst && (state_q == S_IDLE);
    assign w_busy       = (state_q == S_BUSY);
    assign core_stall   = (w_idle && req_valid && w_legal) || w_busy;
    assign misalign_err = w_idle && req_valid && !w_legal;
    assign bus_err      = (state_q == S_DONE) && berr_q;
    assign mem_req      = w_busy;
    assign mem_we       = w_busy && we_q;
    assign mem_be       = w_busy ? be_q    : 4'b0000;
    assign mem_addr     = w_busy ? addr_q  : 32'h0;
    assign mem_wdata    = w_busy ? wdata_q : 32'h0;
    assign rsp_rdata    = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_bus_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_dmem_bus_if : vector table plus hand sequences for timeout and reset.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_dmem_bus_if;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_write;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] rsp_rdata;
    logic        core_stall;
    logic        misalign_err;
    logic        bus_err;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    dmem_bus_if #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_rdata    (rsp_rdata),
        .core_stall   (core_stall),
        .misalign_err (misalign_err),
        .bus_err      (bus_err),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_be       (mem_be),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        write;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          waits;
        logic        mis;
        logic [3:0]  be;
        logic [31:0] maddr;
        logic [31:0] mwdata;
        logic [31:0] rsp;
    } vec_t;

    localparam int N_VEC = 12;
    vec_t        vecs [N_VEC];
    logic [31:0] sb_q [$];
    int          checks   = 0;
    int          failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        req_valid = 1'b0;
        req_write = 1'b0;
        req_size  = 2'b00;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_stall"}, {31'h0, core_stall}, 32'h0);
        chk({tag, "_mreq"},  {31'h0, mem_req},    32'h0);
        chk({tag, "_be"},    {28'h0, mem_be},     32'h0);
        chk({tag, "_addr"},  mem_addr,            32'h0);
        chk({tag, "_wdata"}, mem_wdata,           32'h0);
        chk({tag, "_errs"},  {30'h0, misalign_err, bus_err}, 32'h0);
    endtask

    task automatic run_txn(input vec_t v);
        int stalls;
        logic [31:0] exp_rsp;
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_write = v.write;
        req_size  = v.size;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        mem_ready = 1'b0;
        @(negedge clk);
        chk("acc_stall",    {31'h0, core_stall},   {31'h0, ~v.mis});
        chk("acc_misalign", {31'h0, misalign_err}, {31'h0, v.mis});
        chk("acc_mreq",     {31'h0, mem_req},      32'h0);
        if (v.mis) begin
            @(posedge clk); #1;
            req_valid = 1'b0;
            @(negedge clk);
            chk_quiet("mis_after");
            return;
        end
        sb_q.push_back(v.rsp);
        stalls = int'(core_stall);
        for (int i = 0; i <= v.waits; i++) begin
            @(posedge clk); #1;
            mem_ready = (i == v.waits);
            mem_rdata = (i == v.waits) ? v.rdata : 32'h0BAD_0BAD;
            @(negedge clk);
            stalls += int'(core_stall);
            chk("busy_mreq",  {31'h0, mem_req}, 32'h1);
            chk("busy_we",    {31'h0, mem_we},  {31'h0, v.write});
            chk("busy_be",    {28'h0, mem_be},  {28'h0, v.be});
            chk("busy_addr",  mem_addr,         v.maddr);
            chk("busy_wdata", mem_wdata,        v.mwdata);
        end
        @(posedge clk); #1;
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        @(negedge clk);
        chk("done_stall",  {31'h0, core_stall}, 32'h0);
        chk("done_mreq",   {31'h0, mem_req},    32'h0);
        chk("done_be",     {28'h0, mem_be},     32'h0);
        chk("done_buserr", {31'h0, bus_err},    32'h0);
        chk("stall_cycles", stalls, v.waits + 2);
        if (sb_q.size() == 0) begin
            chk("sb_underflow", 32'h1, 32'h0);
        end else begin
            exp_rsp = sb_q.pop_front();
            chk("rsp_rdata", rsp_rdata, exp_rsp);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk_quiet("post_done");
    endtask

    initial begin
        vec_t vx;
        int   nreq;
        bit   done_seen;
        //         wr    sz     addr          wdata         rdata         wt mis be       maddr         mwdata        rsp
        vecs[0]  = '{1'b0, 2'b00, 32'h0001_0008, 32'h0000_0000, 32'hDEAD_BEEF, 0, 1'b0, 4'b1111, 32'h0001_0008, 32'h0000_0000, 32'hDEAD_BEEF};
        vecs[1]  = '{1'b1, 2'b10, 32'h0001_0003, 32'h0000_00A5, 32'h5555_AAAA, 0, 1'b0, 4'b1000, 32'h0001_0000, 32'hA5A5_A5A5, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b0, 2'b01, 32'h0001_0002, 32'h0000_0000, 32'h1234_5678, 3, 1'b0, 4'b1100, 32'h0001_0000, 32'h0000_0000, 32'h0000_1234};
        vecs[3]  = '{1'b0, 2'b00, 32'h0001_0006, 32'h0000_0000, 32'h0000_0000, 0, 1'b1, 4'b0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
        vecs[4]  = '{1'b0, 2'b11, 32'h0001_0000, 32'h0000_0000, 32'h0000_0000, 0, 1'b1, 4'b0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
        vecs[5]  = '{1'b0, 2'b10, 32'h0001_0001, 32'h0000_0000, 32'h1234_5678, 1, 1'b0, 4'b0010, 32'h0001_0000, 32'h0000_0000, 32'h0000_0056};
        vecs[6]  = '{1'b1, 2'b01, 32'h0001_0002, 32'hFFFF_BEEF, 32'h0000_0000, 0, 1'b0, 4'b1100, 32'h0001_0000, 32'hBEEF_BEEF, 32'h0000_0056};
        vecs[7]  = '{1'b1, 2'b00, 32'h0000_0010, 32'hCAFE_F00D, 32'h0000_0000, 2, 1'b0, 4'b1111, 32'h0000_0010, 32'hCAFE_F00D, 32'h0000_0056};
        vecs[8]  = '{1'b0, 2'b01, 32'h0002_0000, 32'h0000_0000, 32'hAABB_CCDD, 0, 1'b0, 4'b0011, 32'h0002_0000, 32'h0000_0000, 32'h0000_CCDD};
        vecs[9]  = '{1'b0, 2'b01, 32'h0001_0001, 32'h0000_0000, 32'h0000_0000, 0, 1'b1, 4'b0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
        vecs[10] = '{1'b0, 2'b10, 32'h0001_0003, 32'h0000_0000, 32'h8011_2233, 0, 1'b0, 4'b1000, 32'h0001_0000, 32'h0000_0000, 32'h0000_0080};
        vecs[11] = '{1'b1, 2'b10, 32'h0001_0002, 32'h1234_5677, 32'h0000_0000, 1, 1'b0, 4'b0100, 32'h0001_0000, 32'h7777_7777, 32'h0000_0080};

        idle_inputs();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_quiet("reset");
        chk("reset_rsp", rsp_rdata, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk_quiet("idle");

        for (int k = 0; k < N_VEC; k++) begin
            run_txn(vecs[k]);
        end

        // Timeout: memory never answers.
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_size  = 2'b00;
        req_addr  = 32'h0000_0100;
        mem_ready = 1'b0;
        @(negedge clk);
        chk("to_acc_stall", {31'h0, core_stall}, 32'h1);
        nreq      = 0;
        done_seen = 1'b0;
        for (int i = 0; i < 40 && !done_seen; i++) begin
            @(negedge clk);
            if (mem_req) begin
                nreq++;
            end else begin
                done_seen = 1'b1;
                chk("to_buserr", {31'h0, bus_err},    32'h1);
                chk("to_stall",  {31'h0, core_stall}, 32'h0);
                chk("to_rsp",    rsp_rdata,           32'h0);
            end
        end
        chk("to_done_seen", {31'h0, done_seen}, 32'h1);
        chk("to_mreq_cycles", nreq, 16);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk_quiet("to_after");

        // Seed a non-zero response so the reset clear is observable.
        vx = '{1'b0, 2'b00, 32'h0001_0010, 32'h0, 32'h2468_ACE0, 0, 1'b0, 4'b1111, 32'h0001_0010, 32'h0, 32'h2468_ACE0};
        run_txn(vx);

        // Asynchronous reset in the middle of the second BUSY cycle.
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_size  = 2'b00;
        req_addr  = 32'h0001_0004;
        @(posedge clk);
        @(posedge clk); #1;
        chk("rst_pre_mreq", {31'h0, mem_req}, 32'h1);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_mreq",  {31'h0, mem_req},    32'h0);
        chk("rst_stall", {31'h0, core_stall}, 32'h0);
        chk("rst_be",    {28'h0, mem_be},     32'h0);
        chk("rst_rsp",   rsp_rdata,           32'h0);
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst       = 1'b1;
        mem_ready = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("stray_mreq",  {31'h0, mem_req},    32'h0);
        chk("stray_stall", {31'h0, core_stall}, 32'h0);
        @(posedge clk); #1;
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        @(negedge clk);
        chk("stray_rsp", rsp_rdata, 32'h0);
        vx = '{1'b0, 2'b00, 32'h0001_0004, 32'h0, 32'h1357_9BDF, 2, 1'b0, 4'b1111, 32'h0001_0004, 32'h0, 32'h1357_9BDF};
        run_txn(vx);

        chk("sb_drained", sb_q.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_bus_if.md
Name: dmem_bus_if

Overview:
Data-memory access unit sitting directly downstream of the pipelined core's MEM stage. It turns the core's per-cycle memory request (address, store data, write flag, size) into a byte-enabled, word-aligned request on a variable-latency memory bus. It stalls the core until the access completes and returns load data right-aligned to bit 0, ready for the core's load sign/zero extender. It also detects misaligned accesses and bus timeouts.

Parameters:
- TIMEOUT_CYCLES, 16: maximum BUSY cycles waiting for mem_ready before the access is aborted; must be >= 1.
- CNT_W, 5: width of the wait counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  core memory request (mreq from MEM stage); held stable by the core while core_stall=1.
- req_write  in  1  1=store, 0=load.
- req_size  in  2  00=word, 01=half, 10=byte, 11=reserved.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- rsp_rdata  out  32  load data, right-aligned, upper unused bits zero.
- core_stall  out  1  freeze IF/ID/EX/MEM pipeline registers.
- misalign_err  out  1  one-cycle pulse: misaligned or reserved-size request dropped.
- bus_err  out  1  one-cycle pulse: access aborted by timeout.
- mem_req  out  1  memory request valid.
- mem_we  out  1  memory write enable.
- mem_be  out  4  byte lane enables; bit i selects bits [8i+7:8i].
- mem_addr  out  32  word address, bits [1:0] always 0.
- mem_wdata  out  32  lane-replicated store data.
- mem_rdata  in  32  memory read data; valid when mem_ready=1.
- mem_ready  in  1  access-complete strobe from memory.

Behaviour:
- Reset: rst low asynchronously forces IDLE. The counter and all captured registers clear. Every output goes to 0, including rsp_rdata. This applies mid-access; an in-flight mem_req drops immediately.
- FSM states: IDLE, BUSY, DONE.
- IDLE with req_valid=1 and an aligned, legal size:
  - core_stall=1 combinationally in the same cycle.
  - Capture write flag, size, addr[1:0], word address, lane data and byte enables.
  - Next state BUSY.
- IDLE with req_valid=1 and misaligned (half with addr[0]=1, word with addr[1:0]!=0, or size=11):
  - No memory access; misalign_err=1 in the same cycle.
  - core_stall=0; stay in IDLE.
- BUSY:
  - mem_req=1; mem_we, mem_be, mem_addr and mem_wdata are driven from the captured registers and are stable the whole state.
  - core_stall=1; the counter increments each cycle.
  - mem_ready=1: on a load, latch mem_rdata shifted right by 8*addr[1:0] and masked to the access size. Go to DONE.
  - Counter reaches TIMEOUT_CYCLES without mem_ready: go to DONE with bus_err=1 for that DONE cycle and rsp_rdata=0.
- DONE:
  - core_stall=0; rsp_rdata holds the result; mem_req=0.
  - The core advances this cycle, and the still-present request is not re-accepted.
  - Next state IDLE; the counter clears.
- Byte enables: byte = 0001<<addr[1:0]; half = 0011<<addr[1:0]; word = 1111. mem_be=0 whenever mem_req=0.
- Store data: byte = {4{wdata[7:0]}}, half = {2{wdata[15:0]}}, word = wdata.
- Minimum access latency: accept cycle + 1 BUSY cycle + DONE cycle, i.e. 2 stall cycles.
- mem_ready outside BUSY is ignored.
- rsp_rdata holds its last value until the next load completes. Stores do not modify it.
- req_valid=0 in IDLE: every output 0 except rsp_rdata.

Test Plan:
- Word load: req addr=0x0001_0008, size=00, load; mem_ready=1 on the first BUSY cycle with mem_rdata=0xDEADBEEF -> mem_addr=0x0001_0008, mem_be=1111, core_stall high exactly 2 cycles, rsp_rdata=0xDEADBEEF in DONE.
- Byte store: addr=0x0001_0003, size=10, wdata=0x0000_00A5 -> mem_we=1, mem_be=1000, mem_addr=0x0001_0000, mem_wdata=0xA5A5A5A5.
- Half load with 3 wait states: addr=0x0001_0002, size=01, mem_rdata=0x1234_5678, mem_ready on the 4th BUSY cycle -> rsp_rdata=0x0000_1234, core_stall high 5 cycles.
- Misaligned: word load addr=0x0001_0006 -> misalign_err=1 for one cycle, mem_req never asserted, core_stall=0. Repeat with size=11 -> same response.
- Timeout: TIMEOUT_CYCLES=16, mem_ready held 0 -> mem_req high 16 cycles, then bus_err=1 and core_stall=0 in DONE, rsp_rdata=0, back to IDLE.
- Reset mid-access: assert rst low during the 2nd BUSY cycle (asynchronously, between clock edges) -> mem_req, core_stall and mem_be go to 0 immediately. After release, a stray mem_ready is ignored and a new load completes normally.
